button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 145 ++++++++++++++
 tb/tb_button_conditioner.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Four-button front end: 2-flop sync, per-button debounce, and a priority issue
// stage producing one-hot press pulses. Auto-repeat while held: BTN_AUTOREPEAT_EN.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20,
   parameter int unsigned REPEAT_CYCLES   = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] buttons_n,
   output logic [3:0] buttons_pressed,
   output logic [3:0] buttons_level
);

   localparam int unsigned N_BTN = 4;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Elaboration-time parameter sanity.
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
   end
   if (64'(DEBOUNCE_CYCLES) > (64'(1) << CNT_W)) begin : g_bad_db_width
      $error("button_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES-1");
   end
   if (64'(REPEAT_CYCLES) > (64'(1) << CNT_W)) begin : g_bad_rpt_width
      $error("button_conditioner: CNT_W too narrow for REPEAT_CYCLES-1");
   end

   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;
   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] level_nxt;
   logic [N_BTN-1:0] rise;
   logic [N_BTN-1:0] pending;
   logic [N_BTN-1:0] pending_nxt;
   logic [N_BTN-1:0] grant;
   logic [N_BTN-1:0] pressed;
   logic [N_BTN-1:0] rpt_fire;
   logic [CNT_W-1:0] db_cnt     [N_BTN];
   logic [CNT_W-1:0] db_cnt_nxt [N_BTN];

   // Keys are active-low; the synchroniser stores "pressed" as 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= ~buttons_n;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      level_nxt = level;
      rise      = '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
         db_cnt_nxt[i] = '0;
         if (sync2[i] != level[i]) begin
            if (db_cnt[i] == DB_LAST) begin
               level_nxt[i] = sync2[i];
               rise[i]      = sync2[i];
            end else begin
               db_cnt_nxt[i] = db_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= '0;
         for (int i = 0; i < int'(N_BTN); i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         level <= level_nxt;
         for (int i = 0; i < int'(N_BTN); i++) begin
            db_cnt[i] <= db_cnt_nxt[i];
         end
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] rpt_cnt     [N_BTN];
   logic [CNT_W-1:0] rpt_cnt_nxt [N_BTN];

   // Repeat timer runs only while the debounced level is held; idle level clears it.
   always_comb begin
      rpt_fire = '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
         rpt_cnt_nxt[i] = '0;
         if (level[i]) begin
            if (rpt_cnt[i] == RPT_LAST) begin
               rpt_fire[i] = 1'b1;
            end else begin
               rpt_cnt_nxt[i] = rpt_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_BTN); i++) begin
            rpt_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(N_BTN); i++) begin
            rpt_cnt[i] <= rpt_cnt_nxt[i];
         end
      end
   end
`else
   assign rpt_fire = '0;
`endif

   // Highest pending index wins, matching the CPU vector priority.
   always_comb begin
      grant = '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
         if (pending[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
         end
      end
      pending_nxt = (pending & ~grant) | rise | rpt_fire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         pressed <= '0;
      end else begin
         pending <= pending_nxt;
         pressed <= grant;
      end
   end

   assign buttons_pressed = pressed;
   assign buttons_level   = level;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
// with a window-based reference model and directed plus randomized scenarios.
module tb_button_conditioner;

   localparam int unsigned DB = 4;
   localparam int unsigned RP = 10;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit REPEAT_ON = 1'b1;
`else
   localparam bit REPEAT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] buttons_n = 4'hF;
   logic [3:0] buttons_pressed;
   logic [3:0] buttons_level;

   int n_cmp  = 0;
   int n_fail = 0;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .CNT_W          (20),
      .REPEAT_CYCLES  (RP)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .buttons_n      (buttons_n),
      .buttons_pressed(buttons_pressed),
      .buttons_level  (buttons_level)
   );

   always #5 clk = ~clk;

   // Reference model: a level flips once the last DB synchronised samples since the
   // previous flip all disagree with it; presses are a set drained highest-first.
   logic [3:0]  m_s1 = '0, m_s2 = '0, m_level = '0, m_pending = '0;
   logic [3:0]  exp_pressed = '0, exp_level = '0;
   int unsigned m_held [4];
   bit          hq [4][$];

   always @(posedge clk or negedge rst_n) begin : model
      logic [3:0] old_level;
      int         top;
      bit         all_diff;
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_level = '0; m_pending = '0;
         exp_pressed = '0; exp_level = '0;
         for (int i = 0; i < 4; i++) begin
            m_held[i] = 0;
            hq[i].delete();
         end
      end else begin
         old_level   = m_level;
         exp_pressed = '0;
         top         = -1;
         for (int i = 0; i < 4; i++) if (m_pending[i]) top = i;
         if (top >= 0) begin
            exp_pressed[top] = 1'b1;
            m_pending[top]   = 1'b0;
         end
         for (int i = 0; i < 4; i++) begin
            if (old_level[i]) begin
               m_held[i]++;
               if (REPEAT_ON && (m_held[i] % RP == 0)) m_pending[i] = 1'b1;
            end else begin
               m_held[i] = 0;
            end
         end
         for (int i = 0; i < 4; i++) begin
            hq[i].push_back(m_s2[i]);
            if (hq[i].size() > int'(DB)) void'(hq[i].pop_front());
            all_diff = (hq[i].size() == int'(DB));
            for (int k = 0; k < hq[i].size(); k++)
               if (hq[i][k] == old_level[i]) all_diff = 1'b0;
            if (all_diff) begin
               m_level[i] = ~old_level[i];
               hq[i].delete();
               if (m_level[i]) m_pending[i] = 1'b1;
            end
         end
         m_s2      = m_s1;
         m_s1      = ~buttons_n;
         exp_level = m_level;
      end
   end

   task automatic do_reset(input logic [3:0] keys);
      @(negedge clk);
      rst_n     = 1'b0;
      buttons_n = keys;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      buttons_n = 4'hF;
      #1 rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (buttons_pressed !== 4'b0 || buttons_level !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_asserted: got pressed=%b level=%b want 0000/0000",
                  buttons_pressed, buttons_level);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (buttons_pressed !== 4'b0 || buttons_level !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle edge %0d: got pressed=%b level=%b want 0000/0000",
                     e, buttons_pressed, buttons_level);
         end
      end
   endtask

   task automatic test_single_press();
      logic [3:0] ep, el;
      do_reset(4'b1011);
      for (int e = 1; e <= 26; e++) begin
         @(posedge clk); @(negedge clk);
         el = (e >= 6 && e <= 21) ? 4'b0100 : 4'b0000;
         ep = (e == 7 || (REPEAT_ON && e == 17)) ? 4'b0100 : 4'b0000;
         n_cmp++;
         if (buttons_pressed !== ep) begin
            n_fail++;
            $display("FAIL single_pressed edge %0d: got %b want %b", e, buttons_pressed, ep);
         end
         n_cmp++;
         if (buttons_level !== el) begin
            n_fail++;
            $display("FAIL single_level edge %0d: got %b want %b", e, buttons_level, el);
         end
         if (e == 16) buttons_n = 4'hF;
      end
   endtask

   task automatic test_glitch();
      do_reset(4'hF);
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            buttons_n = (c < 3) ? 4'b1110 : 4'b1111;
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (buttons_pressed !== 4'b0 || buttons_level !== 4'b0) begin
               n_fail++;
               $display("FAIL glitch rep %0d cyc %0d: got pressed=%b level=%b want 0000/0000",
                        r, c, buttons_pressed, buttons_level);
            end
         end
      end
      repeat (6) begin
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (buttons_pressed !== 4'b0 || buttons_level !== 4'b0) begin
            n_fail++;
            $display("FAIL glitch_tail: got pressed=%b level=%b want 0000/0000",
                     buttons_pressed, buttons_level);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] ep, el;
      do_reset(4'b0000);
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk); @(negedge clk);
         el = (e >= 6) ? 4'b1111 : 4'b0000;
         case (e)
            7:       ep = 4'b1000;
            8:       ep = 4'b0100;
            9:       ep = 4'b0010;
            10:      ep = 4'b0001;
            default: ep = 4'b0000;
         endcase
         n_cmp++;
         if (buttons_pressed !== ep || buttons_level !== el) begin
            n_fail++;
            $display("FAIL simultaneous edge %0d: got pressed=%b level=%b want %b/%b",
                     e, buttons_pressed, buttons_level, ep, el);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ep, el;
      do_reset(4'b1110);
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk); @(negedge clk);
         el = (e >= 7) ? 4'b1001 : (e == 6) ? 4'b0001 : 4'b0000;
         ep = (e == 7) ? 4'b0001 : (e == 8) ? 4'b1000 : 4'b0000;
         n_cmp++;
         if (buttons_pressed !== ep || buttons_level !== el) begin
            n_fail++;
            $display("FAIL back_to_back edge %0d: got pressed=%b level=%b want %b/%b",
                     e, buttons_pressed, buttons_level, ep, el);
         end
         if (e == 1) buttons_n = 4'b0110;
      end
   endtask

   task automatic test_reset_mid_debounce();
      logic [3:0] ep, el;
      do_reset(4'b1101);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (buttons_pressed !== 4'b0 || buttons_level !== 4'b0) begin
         n_fail++;
         $display("FAIL mid_reset_asserted: got pressed=%b level=%b want 0000/0000",
                  buttons_pressed, buttons_level);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk); @(negedge clk);
         el = (e >= 6) ? 4'b0010 : 4'b0000;
         ep = (e == 7) ? 4'b0010 : 4'b0000;
         n_cmp++;
         if (buttons_pressed !== ep || buttons_level !== el) begin
            n_fail++;
            $display("FAIL mid_reset edge %0d: got pressed=%b level=%b want %b/%b",
                     e, buttons_pressed, buttons_level, ep, el);
         end
      end
   endtask

   task automatic test_autorepeat();
      logic [3:0] ep, el;
      do_reset(4'b0111);
      for (int e = 1; e <= 70; e++) begin
         @(posedge clk); @(negedge clk);
         if (e <= 45) begin
            el = (e >= 6) ? 4'b1000 : 4'b0000;
            ep = (e == 7 || e == 17 || e == 27 || e == 37) ? 4'b1000 : 4'b0000;
         end else begin
            el = exp_level;
            ep = exp_pressed;
         end
         n_cmp++;
         if (buttons_pressed !== ep || buttons_level !== el) begin
            n_fail++;
            $display("FAIL autorepeat edge %0d: got pressed=%b level=%b want %b/%b",
                     e, buttons_pressed, buttons_level, ep, el);
         end
         if (e == 40) buttons_n = 4'hF;
      end
   endtask

   task automatic test_random();
      int len;
      do_reset(4'hF);
      for (int seg = 0; seg < 70; seg++) begin
         buttons_n = 4'($urandom_range(0, 15));
         len       = int'($urandom_range(1, 12));
         for (int c = 0; c < len; c++) begin
            @(posedge clk); @(negedge clk);
            n_cmp++;
            if (buttons_pressed !== exp_pressed) begin
               n_fail++;
               $display("FAIL random_pressed seg %0d: got %b want %b",
                        seg, buttons_pressed, exp_pressed);
            end
            n_cmp++;
            if (buttons_level !== exp_level) begin
               n_fail++;
               $display("FAIL random_level seg %0d: got %b want %b",
                        seg, buttons_level, exp_level);
            end
            n_cmp++;
            if (!$onehot0(buttons_pressed)) begin
               n_fail++;
               $display("FAIL random_onehot seg %0d: got %b want at most one bit",
                        seg, buttons_pressed);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_debounce();
      if (REPEAT_ON) test_autorepeat();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
